fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the IF stage. Owns the fetch PC and chip-enable, and runs
//  a req/ack transaction with instruction memory. Sits between instruction ROM and the
//  IF/ID pipeline register.
//  Absorbs pipeline stall via a 1-entry skid buffer; redirects on branch with in-flight kill.
// PARAMETERS
//  ADDR_W    32            fetch address width
//  INST_W    32            instruction width
//  RESET_PC  32'h0000_0000 PC loaded while in reset
// PORTS
//  clk            in   1       clock, rising edge
//  rst            in   1       reset, asynchronous, active-low
//  stall          in   1       IF/ID hold: if_* not consumed this cycle
//  branch_flag    in   1       redirect request, 1-cycle pulse
//  branch_target  in   ADDR_W  redirect address, bits[1:0] ignored
//  mem_req        out  1       instruction-memory request
//  mem_addr       out  ADDR_W  request address (= pc)
//  mem_ack        in   1       response valid; may arrive same cycle as req
//  mem_rdata      in   INST_W  instruction, valid with mem_ack
//  pc             out  ADDR_W  current fetch PC
//  ce             out  1       chip enable (ChipEnable/ChipDisable)
//  if_valid       out  1       if_inst/if_pc valid toward IF/ID
//  if_pc          out  ADDR_W  address of if_inst
//  if_inst        out  INST_W  fetched instruction
// BEHAVIOUR
//  Reset (rst=0, async): state=S_RST, pc=RESET_PC, ce=0, if_valid=0, if_pc=0, if_inst=0;
//    skid empty, kill=0, redir_pc=0. mem_req=0 in S_RST.
//  FSM:
//    S_RST   -> S_REQ on first edge after release; ce<=1 (ce stays 1 until reset).
//    S_REQ   -> mem_req=1, mem_addr=pc; both held stable until mem_ack.
//    S_BLOCK -> mem_req=0; entered when an ack fills the skid; -> S_REQ when skid drains.
//  Transaction rules:
//    - A new request starts only when the skid is empty.
//    - Consume = if_valid & ~stall.
//  Ack handling (S_REQ, mem_ack=1, kill=0), with ack at edge N:
//    - pc<=pc+4.
//    - If output empty or consumed this cycle: if_inst<=mem_rdata, if_pc<=pc, if_valid<=1.
//      Data is visible after edge N (1-cycle latency).
//    - Else: data goes to the skid (sk_inst, sk_pc, sk_valid<=1) and state -> S_BLOCK.
//  On consume:
//    - If skid valid, the output loads from the skid and the skid clears.
//    - Else, if no accepted ack this cycle, if_valid<=0.
//    - Zero-wait memory with stall=0 gives 1 instr/cycle.
//  Branch (branch_flag=1):
//    - Flushes both entries: if_valid<=0, sk_valid<=0. Branch beats consume, stall and ack.
//    - Not in S_REQ, or in S_REQ with mem_ack=1: pc<=target, next state S_REQ.
//      Any ack data this cycle is dropped.
//    - In S_REQ with no ack: kill<=1, redir_pc<=target; mem_addr stays at the old pc.
//      Next ack with kill=1: data discarded, pc<=redir_pc, kill<=0, stay S_REQ.
//      A further branch while kill=1 overwrites redir_pc (latest wins).
//  Arithmetic: pc+4 modulo 2^ADDR_W (FFFF_FFFC -> 0000_0000).
//    Target low 2 bits forced 00; pc[1:0] always 00.
//  Reset mid-transaction: the outstanding request is abandoned.
//    Memory sees mem_req fall asynchronously.
//  Invariants: no instruction duplicated or lost; if_pc strictly +4 between branches.
// STRUCTURE
//  Shared defines include:
//    - state encodings S_RST/S_REQ/S_BLOCK
//    - RstEnable (1'b0 here)
//    - ChipEnable/ChipDisable, ZeroWord
//    - InstAddrBus/InstBus widths
//  Sub-module fetch_skid_buf: 1-entry {pc,inst} buffer with load/drain/flush ports.
//  FSM, pc/kill logic and output register stay in fetch_ctrl.
// TESTING
//  1 Reset mid-run (rst=0 at cycle 10) -> all outputs 0, pc=0, ce=0 immediately.
//    Release -> ce=1 after edge 1, mem_req=1 with addr 0x0 after edge 1.
//  2 Zero-wait (ack=req), stall=0, 6 cycles -> mem_addr 0,4,8,C,10,14.
//    if_pc follows one cycle later, if_valid continuous.
//  3 Zero-wait, stall=1 for 3 cycles while if_pc=0x8 -> skid holds 0xC, mem_req low.
//    if_pc stays 0x8; after release sequence 0x8,0xC,0x10 with no gap or duplicate.
//  4 3-wait-state memory, branch to 0x100 while req at 0x8 pending -> mem_addr stays 0x8.
//    Ack data discarded, next mem_addr=0x100, first if_pc=0x100.
//  5 Branch to 0x203 coincident with ack, stall=1, skid full -> if_valid=0, skid empty.
//    Next mem_addr=0x200.
//  6 RESET_PC=32'hFFFF_FFFC, zero-wait -> mem_addr FFFF_FFFC then 0000_0000.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer.
//   - fetch_state_e : sequencer states S_RST / S_REQ / S_BLOCK
//   - RstEnable     : level of rst that holds the block in reset (active-low)
//   - ChipEnable / ChipDisable : ce levels
//   - ZeroWord      : all-zero instruction word
//   - InstAddrBus / InstBus    : default address and instruction widths
package fetch_ctrl_pkg;

   localparam int unsigned InstAddrBus = 32;
   localparam int unsigned InstBus     = 32;

   localparam logic RstEnable   = 1'b0;
   localparam logic ChipEnable  = 1'b1;
   localparam logic ChipDisable = 1'b0;

   localparam logic [InstBus-1:0] ZeroWord = '0;

   typedef enum logic [1:0] {
      S_RST   = 2'b00,
      S_REQ   = 2'b01,
      S_BLOCK = 2'b10
   } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {pc, inst} holding buffer used when the IF/ID output register is full
// and an instruction arrives anyway.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   load, load_pc/inst  capture an entry (sets valid)
//   drain               entry has been moved to the output register (clears valid)
//   flush               discard the entry; beats load and drain
//   valid, buf_pc/inst  current contents
module fetch_skid_buf
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned ADDR_W = InstAddrBus,
   parameter int unsigned INST_W = InstBus
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_pc,
   input  logic [INST_W-1:0] load_inst,
   input  logic              drain,
   input  logic              flush,
   output logic              valid,
   output logic [ADDR_W-1:0] buf_pc,
   output logic [INST_W-1:0] buf_inst
);

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         valid    <= 1'b0;
         buf_pc   <= '0;
         buf_inst <= '0;
      end else if (flush) begin
         valid <= 1'b0;
      end else if (load) begin
         valid    <= 1'b1;
         buf_pc   <= load_pc;
         buf_inst <= load_inst;
      end else if (drain) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer for the IF stage. Owns the fetch PC and chip enable,
// runs a req/ack handshake with instruction memory and feeds the IF/ID register.
// A one-entry skid absorbs an instruction that arrives while IF/ID is stalled;
// branches flush both entries and kill a request that is still outstanding.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   stall                    IF/ID did not take if_* this cycle
//   branch_flag/target       redirect pulse and address (target[1:0] ignored)
//   mem_req, mem_addr        request to instruction memory (mem_addr = pc)
//   mem_ack, mem_rdata       response; ack may come in the same cycle as req
//   pc, ce                   fetch PC and chip enable
//   if_valid, if_pc, if_inst instruction toward IF/ID
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int unsigned       ADDR_W   = InstAddrBus,
   parameter int unsigned       INST_W   = InstBus,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              branch_flag,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [INST_W-1:0] mem_rdata,
   output logic [ADDR_W-1:0] pc,
   output logic              ce,
   output logic              if_valid,
   output logic [ADDR_W-1:0] if_pc,
   output logic [INST_W-1:0] if_inst
);

   fetch_state_e      state;
   logic              kill;
   logic [ADDR_W-1:0] redir_pc;

   logic              sk_valid;
   logic [ADDR_W-1:0] sk_pc;
   logic [INST_W-1:0] sk_inst;

   logic              consume;
   logic              take_ack;
   logic              sk_load;
   logic              sk_drain;
   logic [ADDR_W-1:0] branch_pc;
   logic              unused_tgt;

   assign consume   = if_valid & ~stall;
   // Ack that actually delivers an instruction: not killed, not overridden by a branch.
   assign take_ack  = (state == S_REQ) & mem_ack & ~kill & ~branch_flag;
   // Output register still occupied, so the new instruction parks in the skid.
   assign sk_load   = take_ack & if_valid & ~consume;
   assign sk_drain  = ~branch_flag & sk_valid & consume;
   assign branch_pc = {branch_target[ADDR_W-1:2], 2'b00};
   assign unused_tgt = ^branch_target[1:0];

   // Combinational from state so that an asynchronous reset drops the request at once.
   assign mem_req  = (state == S_REQ);
   assign mem_addr = pc;

   fetch_skid_buf #(
      .ADDR_W (ADDR_W),
      .INST_W (INST_W)
   ) u_skid (
      .clk       (clk),
      .rst       (rst),
      .load      (sk_load),
      .load_pc   (pc),
      .load_inst (mem_rdata),
      .drain     (sk_drain),
      .flush     (branch_flag),
      .valid     (sk_valid),
      .buf_pc    (sk_pc),
      .buf_inst  (sk_inst)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         state    <= S_RST;
         pc       <= {RESET_PC[ADDR_W-1:2], 2'b00};
         ce       <= ChipDisable;
         if_valid <= 1'b0;
         if_pc    <= '0;
         if_inst  <= '0;
         kill     <= 1'b0;
         redir_pc <= '0;
      end else begin
         // Raised on the first edge out of reset and held until the next reset.
         ce <= ChipEnable;
         if (branch_flag) begin
            if_valid <= 1'b0;
            if (state == S_REQ && !mem_ack) begin
               // Request still in flight: keep mem_addr stable, retarget on its ack.
               kill     <= 1'b1;
               redir_pc <= branch_pc;
            end else begin
               pc    <= branch_pc;
               kill  <= 1'b0;
               state <= S_REQ;
            end
         end else begin
            case (state)
               S_RST: begin
                  state <= S_REQ;
               end
               S_REQ: begin
                  if (mem_ack && kill) begin
                     pc   <= redir_pc;
                     kill <= 1'b0;
                     if (consume) if_valid <= 1'b0;
                  end else if (mem_ack) begin
                     pc <= pc + ADDR_W'(4);
                     if (!if_valid || consume) begin
                        if_valid <= 1'b1;
                        if_pc    <= pc;
                        if_inst  <= mem_rdata;
                     end else begin
                        state <= S_BLOCK;
                     end
                  end else if (consume) begin
                     if_valid <= 1'b0;
                  end
               end
               S_BLOCK: begin
                  if (consume) begin
                     if_valid <= 1'b1;
                     if_pc    <= sk_pc;
                     if_inst  <= sk_inst;
                     state    <= S_REQ;
                  end
               end
               default: begin
                  state <= S_RST;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl. A memory model answers requests with a
// configurable number of wait states; a stream model tracks the address of the next
// instruction IF/ID should receive (sequential +4, restarting at branch targets) and
// checks every consumed instruction against it.
module tb_fetch_ctrl;

   localparam int unsigned AW = 32;
   localparam int unsigned IW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          stall;
   logic          branch_flag;
   logic [AW-1:0] branch_target;
   logic          mem_req;
   logic [AW-1:0] mem_addr;
   logic          mem_ack;
   logic [IW-1:0] mem_rdata;
   logic [AW-1:0] pc;
   logic          ce;
   logic          if_valid;
   logic [AW-1:0] if_pc;
   logic [IW-1:0] if_inst;

   // Second instance: reset PC at the top of the address space, zero-wait memory.
   logic          mem_req2;
   logic [AW-1:0] mem_addr2;
   logic          mem_ack2;
   logic [IW-1:0] mem_rdata2;
   logic [AW-1:0] pc2;
   logic          ce2;
   logic          if_valid2;
   logic [AW-1:0] if_pc2;
   logic [IW-1:0] if_inst2;
   logic          zero_bit;
   logic [AW-1:0] zero_addr;

   assign zero_bit   = 1'b0;
   assign zero_addr  = '0;
   assign mem_ack2   = mem_req2;
   assign mem_rdata2 = ~mem_addr2;

   int unsigned   pass_cnt = 0;
   int unsigned   check_cnt = 0;
   int unsigned   wait_states = 0;
   int unsigned   busy_cnt = 0;
   logic          last_req = 1'b0;
   logic [AW-1:0] exp_pc = '0;
   int unsigned   n_consumed = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(
      .ADDR_W   (AW),
      .INST_W   (IW),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_flag   (branch_flag),
      .branch_target (branch_target),
      .mem_req       (mem_req),
      .mem_addr      (mem_addr),
      .mem_ack       (mem_ack),
      .mem_rdata     (mem_rdata),
      .pc            (pc),
      .ce            (ce),
      .if_valid      (if_valid),
      .if_pc         (if_pc),
      .if_inst       (if_inst)
   );

   fetch_ctrl #(
      .ADDR_W   (AW),
      .INST_W   (IW),
      .RESET_PC (32'hFFFF_FFFC)
   ) dut_wrap (
      .clk           (clk),
      .rst           (rst),
      .stall         (zero_bit),
      .branch_flag   (zero_bit),
      .branch_target (zero_addr),
      .mem_req       (mem_req2),
      .mem_addr      (mem_addr2),
      .mem_ack       (mem_ack2),
      .mem_rdata     (mem_rdata2),
      .pc            (pc2),
      .ce            (ce2),
      .if_valid      (if_valid2),
      .if_pc         (if_pc2),
      .if_inst       (if_inst2)
   );

   function automatic logic [IW-1:0] inst_of(input logic [AW-1:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
   endfunction

   // Memory response for the coming edge, decided from the current request.
   task automatic mem_drive();
      if (!rst) begin
         mem_ack   = 1'b0;
         busy_cnt  = 0;
         last_req  = 1'b0;
         mem_rdata = $urandom;
         return;
      end
      if (mem_ack && last_req) busy_cnt = 0;
      last_req = mem_req;
      if (mem_req) begin
         mem_ack = (busy_cnt >= wait_states);
         if (!mem_ack) busy_cnt++;
      end else begin
         mem_ack  = 1'b0;
         busy_cnt = 0;
      end
      mem_rdata = mem_ack ? inst_of(mem_addr) : $urandom;
   endtask

   // One clock: stream and handshake checks around the edge, then new memory response.
   task automatic tick();
      logic          live;
      logic          req_b;
      logic          ack_b;
      logic [AW-1:0] addr_b;
      live   = rst;
      req_b  = mem_req;
      ack_b  = mem_ack;
      addr_b = mem_addr;
      if (live) begin
         check_cnt++;
         if (pc !== mem_addr || pc[1:0] !== 2'b00)
            $display("FAIL pc_addr: pc=%h mem_addr=%h, required equal and word aligned",
                     pc, mem_addr);
         else pass_cnt++;
         if (branch_flag) begin
            exp_pc = {branch_target[AW-1:2], 2'b00};
         end else if (if_valid && !stall) begin
            check_cnt++;
            if (if_pc !== exp_pc || if_inst !== inst_of(exp_pc))
               $display("FAIL stream: if_pc=%h if_inst=%h, required if_pc=%h if_inst=%h",
                        if_pc, if_inst, exp_pc, inst_of(exp_pc));
            else pass_cnt++;
            exp_pc = exp_pc + 32'd4;
            n_consumed++;
         end
      end
      @(posedge clk);
      @(negedge clk);
      if (live && rst && req_b && !ack_b) begin
         check_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== addr_b)
            $display("FAIL req_hold: mem_req=%b mem_addr=%h, required mem_req=1 mem_addr=%h",
                     mem_req, mem_addr, addr_b);
         else pass_cnt++;
      end
      mem_drive();
   endtask

   // Reset in the middle of a cycle, release on a falling edge, then take edge 1.
   task automatic apply_reset();
      #2 rst = 1'b0;
      @(negedge clk);
      mem_drive();
      @(negedge clk);
      stall       = 1'b0;
      branch_flag = 1'b0;
      rst         = 1'b1;
      exp_pc      = '0;
      mem_drive();
      tick();
   endtask

   task automatic test_reset();
      check_cnt++;
      if ({mem_req, ce, if_valid} !== 3'b000 || pc !== '0 || if_pc !== '0 || if_inst !== '0)
         $display("FAIL reset_init: req/ce/valid=%b pc=%h if_pc=%h if_inst=%h, required all 0",
                  {mem_req, ce, if_valid}, pc, if_pc, if_inst);
      else pass_cnt++;
      @(negedge clk);
      rst = 1'b1;
      mem_drive();
      check_cnt++;
      if (ce !== 1'b0 || mem_req !== 1'b0)
         $display("FAIL pre_edge1: ce=%b mem_req=%b, required 0 0", ce, mem_req);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (ce !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h0)
         $display("FAIL edge1: ce=%b mem_req=%b mem_addr=%h, required 1 1 00000000",
                  ce, mem_req, mem_addr);
      else pass_cnt++;
      repeat (8) tick();
      // Asynchronous assertion part-way through a cycle.
      #2 rst = 1'b0;
      #1;
      check_cnt++;
      if ({mem_req, ce, if_valid} !== 3'b000 || pc !== '0 || mem_addr !== '0 ||
          if_pc !== '0 || if_inst !== '0)
         $display("FAIL reset_mid: req/ce/valid=%b pc=%h if_pc=%h if_inst=%h, required all 0",
                  {mem_req, ce, if_valid}, pc, if_pc, if_inst);
      else pass_cnt++;
      @(negedge clk);
      mem_drive();
      @(negedge clk);
      rst    = 1'b1;
      exp_pc = '0;
      mem_drive();
      tick();
      check_cnt++;
      if (ce !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h0)
         $display("FAIL release: ce=%b mem_req=%b mem_addr=%h, required 1 1 00000000",
                  ce, mem_req, mem_addr);
      else pass_cnt++;
   endtask

   task automatic test_zero_wait();
      logic [AW-1:0] a;
      wait_states = 0;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         a = AW'(4 * i);
         check_cnt++;
         if (mem_req !== 1'b1 || mem_addr !== a)
            $display("FAIL zw_addr: mem_req=%b mem_addr=%h, required 1 %h", mem_req, mem_addr, a);
         else pass_cnt++;
         if (i > 0) begin
            check_cnt++;
            if (if_valid !== 1'b1 || if_pc !== a - 32'd4)
               $display("FAIL zw_out: if_valid=%b if_pc=%h, required 1 %h",
                        if_valid, if_pc, a - 32'd4);
            else pass_cnt++;
         end
         tick();
      end
   endtask

   task automatic test_stall();
      wait_states = 0;
      apply_reset();
      repeat (3) tick();
      check_cnt++;
      if (if_valid !== 1'b1 || if_pc !== 32'h8 || mem_addr !== 32'hC)
         $display("FAIL stall_pre: if_valid=%b if_pc=%h mem_addr=%h, required 1 8 c",
                  if_valid, if_pc, mem_addr);
      else pass_cnt++;
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_cnt++;
         if (if_valid !== 1'b1 || if_pc !== 32'h8 || mem_req !== 1'b0)
            $display("FAIL stall_hold: if_valid=%b if_pc=%h mem_req=%b, required 1 8 0",
                     if_valid, if_pc, mem_req);
         else pass_cnt++;
      end
      stall = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check_cnt++;
         if (if_valid !== 1'b1 || if_pc !== AW'(8 + 4 * i))
            $display("FAIL stall_seq: if_valid=%b if_pc=%h, required 1 %h",
                     if_valid, if_pc, AW'(8 + 4 * i));
         else pass_cnt++;
         tick();
      end
   endtask

   task automatic test_wait_branch();
      int k;
      wait_states = 3;
      apply_reset();
      k = 0;
      while (!(mem_req && mem_addr == 32'h8) && k < 40) begin
         tick();
         k++;
      end
      check_cnt++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8 || mem_ack !== 1'b0)
         $display("FAIL wb_find: mem_req=%b mem_addr=%h mem_ack=%b, required 1 8 0",
                  mem_req, mem_addr, mem_ack);
      else pass_cnt++;
      branch_flag   = 1'b1;
      branch_target = 32'h100;
      tick();
      branch_flag = 1'b0;
      check_cnt++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h8 || if_valid !== 1'b0)
         $display("FAIL wb_kill: mem_req=%b mem_addr=%h if_valid=%b, required 1 8 0",
                  mem_req, mem_addr, if_valid);
      else pass_cnt++;
      k = 0;
      while (mem_addr == 32'h8 && k < 10) begin
         tick();
         k++;
      end
      check_cnt++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100)
         $display("FAIL wb_redir: mem_req=%b mem_addr=%h, required 1 100", mem_req, mem_addr);
      else pass_cnt++;
      k = 0;
      while (!if_valid && k < 10) begin
         tick();
         k++;
      end
      check_cnt++;
      if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_inst !== inst_of(32'h100))
         $display("FAIL wb_first: if_valid=%b if_pc=%h if_inst=%h, required 1 100 %h",
                  if_valid, if_pc, if_inst, inst_of(32'h100));
      else pass_cnt++;
   endtask

   task automatic test_branch_skid();
      int k;
      wait_states = 0;
      apply_reset();
      repeat (3) tick();
      stall = 1'b1;
      tick();
      check_cnt++;
      if (mem_req !== 1'b0 || if_pc !== 32'h8 || if_valid !== 1'b1)
         $display("FAIL bs_full: mem_req=%b if_pc=%h if_valid=%b, required 0 8 1",
                  mem_req, if_pc, if_valid);
      else pass_cnt++;
      mem_ack       = 1'b1;
      mem_rdata     = $urandom;
      branch_flag   = 1'b1;
      branch_target = 32'h203;
      tick();
      branch_flag = 1'b0;
      check_cnt++;
      if (if_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h200)
         $display("FAIL bs_flush: if_valid=%b mem_req=%b mem_addr=%h, required 0 1 200",
                  if_valid, mem_req, mem_addr);
      else pass_cnt++;
      stall = 1'b0;
      k = 0;
      while (!if_valid && k < 10) begin
         tick();
         k++;
      end
      check_cnt++;
      if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_inst !== inst_of(32'h200))
         $display("FAIL bs_first: if_valid=%b if_pc=%h if_inst=%h, required 1 200 %h",
                  if_valid, if_pc, if_inst, inst_of(32'h200));
      else pass_cnt++;
      tick();
      check_cnt++;
      if (if_valid !== 1'b1 || if_pc !== 32'h204)
         $display("FAIL bs_next: if_valid=%b if_pc=%h, required 1 204", if_valid, if_pc);
      else pass_cnt++;
   endtask

   task automatic test_wrap();
      wait_states = 0;
      apply_reset();
      check_cnt++;
      if (mem_req2 !== 1'b1 || mem_addr2 !== 32'hFFFF_FFFC)
         $display("FAIL wrap_first: mem_req=%b mem_addr=%h, required 1 fffffffc",
                  mem_req2, mem_addr2);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (mem_addr2 !== 32'h0 || pc2 !== 32'h0 || if_valid2 !== 1'b1 ||
          if_pc2 !== 32'hFFFF_FFFC || if_inst2 !== 32'h0000_0003 || ce2 !== 1'b1)
         $display("FAIL wrap_next: mem_addr=%h pc=%h if_valid=%b if_pc=%h if_inst=%h, required 0 0 1 fffffffc 3",
                  mem_addr2, pc2, if_valid2, if_pc2, if_inst2);
      else pass_cnt++;
      tick();
      check_cnt++;
      if (if_pc2 !== 32'h0 || mem_addr2 !== 32'h4)
         $display("FAIL wrap_seq: if_pc=%h mem_addr=%h, required 0 4", if_pc2, mem_addr2);
      else pass_cnt++;
   endtask

   task automatic test_random();
      int unsigned start;
      wait_states = 0;
      apply_reset();
      start = n_consumed;
      for (int blk = 0; blk < 15; blk++) begin
         wait_states = $urandom_range(0, 3);
         for (int c = 0; c < 200; c++) begin
            stall = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 99) < 4) begin
               branch_flag   = 1'b1;
               branch_target = $urandom;
            end else begin
               branch_flag = 1'b0;
            end
            tick();
         end
      end
      branch_flag = 1'b0;
      stall       = 1'b0;
      repeat (8) tick();
      check_cnt++;
      if (n_consumed - start < 100)
         $display("FAIL rand_progress: consumed=%0d, required at least 100", n_consumed - start);
      else pass_cnt++;
   endtask

   initial begin
      rst           = 1'b1;
      stall         = 1'b0;
      branch_flag   = 1'b0;
      branch_target = '0;
      mem_ack       = 1'b0;
      mem_rdata     = '0;
      #1 rst = 1'b0;
      test_reset();
      test_zero_wait();
      test_stall();
      test_wait_branch();
      test_branch_skid();
      test_wrap();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation still running at %0t, required completion", $time);
      $fatal(1, "timeout");
   end

endmodule
